obuf_arb: RTL and testbench
===========================

// Module: obuf_arb
// PURPOSE
// - Output side of one router output port: responder to the per-direction arb_req bits raised by the five input buffers.
// - Round-robin grants one requesting input port, captures its payload into a small FIFO and drives the output link with vld/rdy.
// - Instanced once per output direction (N, W, S, E, B) in each mesh node.
// PARAMETERS
// - PYLD_W  23  payload width in bits, equal to the input buffer payload width
// - DEPTH   2   output FIFO entries, >=2, power of two
// PORTS
// - clk            in   1          clock
// - rst_n          in   1          reset, asynchronous, active-low
// - arb_req_i      in   5          bit k = input port k requests this output; index order N=0,W=1,S=2,E=3,B=4
// - payload_i      in   5*PYLD_W   slice k = payload_i[k*PYLD_W +: PYLD_W] from input port k
// - arb_gnt_o      out  5          one-hot grant to input port k, or all zero
// - obuf_rdy_o     out  1          FIFO can accept; broadcast to all input ports as their obuf_rdy bit for this direction
// - obuf_vld       out  1          output link valid
// - obuf_rdy_dn    in   1          downstream ready (next node input buffer ibuf_rdy)
// - payload_o      out  PYLD_W     output link payload, head of FIFO
// BEHAVIOUR
// - Reset: arb_gnt_o=0, obuf_rdy_o=1, obuf_vld=0, payload_o=0, priority pointer=0 (N), FIFO empty, all entries 0.
// - Grant is combinational from arb_req_i and pointer ptr: first set bit at index ptr, ptr+1, ... wrapping 4->0; zero when arb_req_i=0.
// - Grant does not depend on obuf_rdy_o. An input port clears its request only on arb_gnt_o[k] & obuf_rdy_o.
// - Accept (push) = |arb_gnt_o & obuf_rdy_o. On push the granted payload slice is written at the tail on the same clk edge.
// - Pointer update only on push: ptr <= (granted index + 1) mod 5. With no push, ptr holds; a held grant stays on the same port.
// - obuf_rdy_o = !full, derived from registered count; no combinational path from obuf_rdy_dn.
// - Pop = obuf_vld & obuf_rdy_dn. obuf_vld = !empty. payload_o = head entry, stable while obuf_vld & !obuf_rdy_dn.
// - Count is 0..DEPTH, width $clog2(DEPTH)+1. Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
// - Push and pop in the same cycle: both take effect and count is unchanged.
// - When full, push cannot occur because obuf_rdy_o=0. There is no bypass from input to output.
// - When empty, pop cannot occur. Zero-cycle flow-through does not exist: minimum latency is 1 cycle from push edge to obuf_vld=1.
// - Throughput is one packet per cycle when the downstream is always ready.
// - Payload slices of non-granted ports are ignored. Grants to ports with arb_req_i[k]=0 never occur.
// - Reset asserted mid-operation: FIFO content is dropped, outputs return to reset values immediately (asynchronous), ptr returns to 0.
// - Assertions: arb_gnt_o is one-hot or zero; arb_gnt_o is a subset of arb_req_i; count<=DEPTH; payload_o stable under backpressure.
// STRUCTURE
// - Shared package mesh_pkg: DIR_N=0, DIR_W=1, DIR_S=2, DIR_E=3, DIR_B=4, NUM_PORTS=5, PYLD_W default.
// - The same package is used by the input buffer and the routing logic.
// - Sub-module rr_arb5: 5-way round-robin arbiter.
//   - Ports: clk, rst_n, req[4:0], adv (=push), gnt[4:0].
//   - Holds ptr internally. Reused by the local/ejection port.
// - The FIFO is inline in obuf_arb, as register array plus pointers and count.
// TESTING
// - Reset, then arb_req_i=5'b00100, obuf_rdy_dn=1 -> arb_gnt_o=5'b00100 in the same cycle; obuf_vld=1 next cycle with payload of port S; ptr=3.
// - arb_req_i=5'b11111 held, each port re-raising after its push, rdy_dn=1 -> grant order N,W,S,E,B,N...; 5 packets in 5 cycles.
// - obuf_rdy_dn=0, two pushes -> obuf_rdy_o=0 after the 2nd push (DEPTH=2); arb_gnt_o stays on the 3rd requester with no push.
//   - Then rdy_dn=1 -> obuf_rdy_o=1 the cycle after the first pop; data pops in FIFO order.
// - FIFO at count=1 with simultaneous push and pop -> count stays 1; payload_o advances to the new entry next cycle.
// - Backpressure with obuf_vld=1, rdy_dn=0 for 10 cycles -> payload_o unchanged; no grant change once the FIFO is full.
// - rst_n pulsed low with 2 entries queued -> obuf_vld=0 and obuf_rdy_o=1 immediately; first grant after reset favours N when N and E both request.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh router definitions: port directions and payload width.
// Used by input buffers, routing logic and output arbiters.
package mesh_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PYLD_W    = 23;

    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_W = 3'd1,
        DIR_S = 3'd2,
        DIR_E = 3'd3,
        DIR_B = 3'd4
    } dir_e;

    function automatic logic [2:0] dir_next(input logic [2:0] d);
        return (d == DIR_B) ? DIR_N : d + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// 5-way round-robin arbiter; the pointer moves past the winner
// only when the grant is actually consumed (adv).
module rr_arb5 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic       adv,
    output logic [4:0] gnt
);
    import mesh_pkg::*;

    logic [2:0] r_ptr;
    logic [2:0] w_idx;
    logic [2:0] w_cand;
    logic       w_hit;

    always_comb begin
        w_idx  = r_ptr;
        w_cand = r_ptr;
        w_hit  = 1'b0;
        gnt    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_hit && req[w_cand]) begin
                w_hit = 1'b1;
                w_idx = w_cand;
            end
            w_cand = dir_next(w_cand);
        end
        if (w_hit) gnt[w_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (adv && w_hit) begin
            r_ptr <= dir_next(w_idx);
        end
    end

endmodule

// File: rtl/obuf_arb.sv
// Router output port: round-robin grant of input ports into a small
// FIFO that drives the output link with a valid/ready handshake.
module obuf_arb #(
    parameter int PYLD_W = mesh_pkg::PYLD_W,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          arb_req_i,
    input  logic [5*PYLD_W-1:0] payload_i,
    output logic [4:0]          arb_gnt_o,
    output logic                obuf_rdy_o,
    output logic                obuf_vld,
    input  logic                obuf_rdy_dn,
    output logic [PYLD_W-1:0]   payload_o
);
    import mesh_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PYLD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;

    logic              w_push;
    logic              w_pop;
    logic [PYLD_W-1:0] w_din;

    rr_arb5 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req_i),
        .adv   (w_push),
        .gnt   (arb_gnt_o)
    );

    // Ready comes only from registered occupancy, never from downstream.
    assign obuf_rdy_o = (r_cnt != CW'(DEPTH));
    assign obuf_vld   = (r_cnt != '0);
    assign w_push     = (|arb_gnt_o) && obuf_rdy_o;
    assign w_pop      = obuf_vld && obuf_rdy_dn;
    assign payload_o  = r_mem[r_rp];

    always_comb begin
        w_din = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (arb_gnt_o[k]) w_din = w_din | payload_i[k*PYLD_W +: PYLD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_din;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(arb_gnt_o));
    a_gnt_subset: assert property (@(posedge clk) disable iff (!rst_n)
        (arb_gnt_o & ~arb_req_i) == 5'd0);
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= CW'(DEPTH));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (obuf_vld && !obuf_rdy_dn) |=> $stable(payload_o));

endmodule

// File: tb/tb_obuf_arb.sv
// Directed bench for obuf_arb: arbitration order, FIFO flow control,
// backpressure and asynchronous reset.
module tb_obuf_arb;

    localparam int PW = 23;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      req;
    logic [5*PW-1:0] pin;
    logic [4:0]      gnt;
    logic            rdy;
    logic            vld;
    logic            rdy_dn;
    logic [PW-1:0]   pout;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obuf_arb #(.PYLD_W(PW), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_req_i   (req),
        .payload_i   (pin),
        .arb_gnt_o   (gnt),
        .obuf_rdy_o  (rdy),
        .obuf_vld    (vld),
        .obuf_rdy_dn (rdy_dn),
        .payload_o   (pout)
    );

    function automatic logic [PW-1:0] pv(input int k);
        return 23'h2A5000 + PW'(k + 1) * 23'h111;
    endfunction

    task automatic do_reset;
        rst_n  = 1'b0;
        req    = '0;
        rdy_dn = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        req    = '0;
        rdy_dn = 1'b0;
        #1;
        checks++;
        if (gnt !== 5'b0) begin
            errs++; $display("FAIL rst_gnt: got %b want 00000", gnt);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errs++; $display("FAIL rst_rdy: got %b want 1", rdy);
        end
        checks++;
        if (vld !== 1'b0) begin
            errs++; $display("FAIL rst_vld: got %b want 0", vld);
        end
        checks++;
        if (pout !== '0) begin
            errs++; $display("FAIL rst_pyld: got %h want 0", pout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        do_reset();
        req    = 5'b00100;
        rdy_dn = 1'b1;
        #1;
        checks++;
        if (gnt !== 5'b00100) begin
            errs++; $display("FAIL single_gnt: got %b want 00100", gnt);
        end
        @(posedge clk); #1;
        req = '0;
        checks++;
        if (vld !== 1'b1) begin
            errs++; $display("FAIL single_vld: got %b want 1", vld);
        end
        checks++;
        if (pout !== pv(2)) begin
            errs++; $display("FAIL single_pyld: got %h want %h", pout, pv(2));
        end
        req = 5'b11111;
        #1;
        checks++;
        if (gnt !== 5'b01000) begin
            errs++; $display("FAIL single_ptr: got %b want 01000", gnt);
        end
        req = '0;
        @(posedge clk); #1;
        checks++;
        if (vld !== 1'b0) begin
            errs++; $display("FAIL single_drain: got %b want 0", vld);
        end
    endtask

    task automatic test_rr;
        logic [4:0] exp;
        do_reset();
        req    = 5'b11111;
        rdy_dn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = 5'b00001 << (i % 5);
            #1;
            checks++;
            if (gnt !== exp) begin
                errs++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp);
            end
            @(posedge clk); #1;
            checks++;
            if (vld !== 1'b1 || rdy !== 1'b1) begin
                errs++;
                $display("FAIL rr_flow[%0d]: vld=%b rdy=%b want 1 1", i, vld, rdy);
            end
            checks++;
            if (pout !== pv(i % 5)) begin
                errs++;
                $display("FAIL rr_pyld[%0d]: got %h want %h", i, pout, pv(i % 5));
            end
        end
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        do_reset();
        rdy_dn = 1'b0;
        req    = 5'b00111;
        @(posedge clk); #1;
        req = 5'b00110;
        @(posedge clk); #1;
        req = 5'b00100;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errs++; $display("FAIL bp_full: got %b want 0", rdy);
        end
        checks++;
        if (gnt !== 5'b00100) begin
            errs++; $display("FAIL bp_hold_gnt: got %b want 00100", gnt);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pout !== pv(0) || vld !== 1'b1) begin
                errs++;
                $display("FAIL bp_stable[%0d]: pyld=%h vld=%b want %h 1", i, pout, vld, pv(0));
            end
            checks++;
            if (gnt !== 5'b00100 || rdy !== 1'b0) begin
                errs++;
                $display("FAIL bp_gnt[%0d]: gnt=%b rdy=%b want 00100 0", i, gnt, rdy);
            end
        end
        rdy_dn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy !== 1'b1) begin
            errs++; $display("FAIL bp_rdy_back: got %b want 1", rdy);
        end
        checks++;
        if (pout !== pv(1)) begin
            errs++; $display("FAIL bp_order1: got %h want %h", pout, pv(1));
        end
        @(posedge clk); #1;
        req = '0;
        checks++;
        if (pout !== pv(2) || vld !== 1'b1) begin
            errs++;
            $display("FAIL bp_order2: pyld=%h vld=%b want %h 1", pout, vld, pv(2));
        end
        @(posedge clk); #1;
        checks++;
        if (vld !== 1'b0 || rdy !== 1'b1) begin
            errs++; $display("FAIL bp_empty: vld=%b rdy=%b want 0 1", vld, rdy);
        end
    endtask

    task automatic test_push_pop;
        do_reset();
        rdy_dn = 1'b0;
        req    = 5'b00001;
        @(posedge clk); #1;
        req    = 5'b01000;
        rdy_dn = 1'b1;
        @(posedge clk); #1;
        req = '0;
        checks++;
        if (pout !== pv(3) || vld !== 1'b1) begin
            errs++;
            $display("FAIL pp_pyld: pyld=%h vld=%b want %h 1", pout, vld, pv(3));
        end
        checks++;
        if (rdy !== 1'b1) begin
            errs++; $display("FAIL pp_count: rdy=%b want 1", rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (vld !== 1'b0) begin
            errs++; $display("FAIL pp_drain: got %b want 0", vld);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        rdy_dn = 1'b0;
        req    = 5'b00011;
        @(posedge clk); #1;
        req = 5'b00010;
        @(posedge clk); #1;
        req = '0;
        checks++;
        if (rdy !== 1'b0 || vld !== 1'b1) begin
            errs++; $display("FAIL mid_full: rdy=%b vld=%b want 0 1", rdy, vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vld !== 1'b0 || rdy !== 1'b1) begin
            errs++; $display("FAIL mid_async: vld=%b rdy=%b want 0 1", vld, rdy);
        end
        checks++;
        if (pout !== '0) begin
            errs++; $display("FAIL mid_pyld: got %h want 0", pout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req   = 5'b01001;
        #1;
        checks++;
        if (gnt !== 5'b00001) begin
            errs++; $display("FAIL mid_ptr: got %b want 00001", gnt);
        end
        @(posedge clk); #1;
        req = 5'b01000;
        checks++;
        if (pout !== pv(0) || vld !== 1'b1) begin
            errs++;
            $display("FAIL mid_first: pyld=%h vld=%b want %h 1", pout, vld, pv(0));
        end
        req    = '0;
        rdy_dn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) pin[k*PW +: PW] = pv(k);
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
